buf_reader: RTL and testbench
=============================

Name: buf_reader

Overview:
- Consumer-side front end for the team's `buffer` FIFO.
- Drains words using the buffer's `avail`/`re`/`dout` interface and presents them downstream on a valid/ready handshake.
- Holds up to 2 words in an internal skid queue, so a downstream stall never causes a read that has to be thrown away.
- Sits between a `buffer` instance (e.g. an instruction or CDB queue) and its pipeline consumer.
- Supports flush and keeps a count of delivered words.

Parameters:
- DATA_L, 16, word width; must match the attached buffer.
- CNT_L, 16, width of the delivered-word counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. rst=0 resets immediately, independent of clk.
- buf_avail  in  1  buffer is non-empty (connects to buffer `avail`).
- buf_re  out  1  read strobe to the buffer (connects to buffer `re`). The buffer acts on its rising edge.
- buf_dout  in  DATA_L  buffer read data. Valid at the clk edge that ends the cycle in which buf_re=1.
- flush  in  1  synchronous discard of all held and in-flight words.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  downstream accepts the word.
- out_data  out  DATA_L  head word of the skid queue.
- out_cnt  out  CNT_L  number of words delivered; wraps modulo 2^CNT_L.

Behaviour:
- Reset (rst=0): FSM goes to IDLE; buf_re=0, out_valid=0, out_data=0, out_cnt=0, queue occupancy=0.
- Reset asserted mid-REQ truncates the strobe immediately. The word the buffer already popped is lost; this is accepted.
- All outputs are registered. There is no combinational path from any input to buf_re or out_valid.
- FSM states: IDLE, REQ, GAP.
- IDLE -> REQ when buf_avail=1 && occ<2 && flush=0. In REQ, buf_re=1 for exactly one cycle.
- REQ -> GAP unconditionally. At that edge, buf_dout is written into the queue tail (occ+1).
- GAP: buf_re=0, guaranteeing a low phase so the buffer's next `re` rising edge is distinct.
- GAP -> REQ if buf_avail=1 && occ<2 (occ evaluated after this edge's pop); otherwise GAP -> IDLE.
- Peak throughput is 1 word per 2 cycles. This is inherent to the edge-triggered buffer strobe.
- occ<2 is checked before REQ, so a capture never overflows the queue, even with out_ready=0 throughout.
- Pop: at an edge with out_valid=1 && out_ready=1, the head is removed and out_cnt increments by 1 (wrap: 0xFFFF -> 0x0000 for CNT_L=16).
- Simultaneous pop and capture: occupancy is unchanged, the head advances, and the new word enters the tail. Order is strictly FIFO.
- out_valid = (occ != 0); out_data = head entry.
- When occ=0, out_data holds its last value; downstream must ignore it.
- Empty buffer: with buf_avail=0, the FSM stays in IDLE. buf_re is never raised into an empty buffer.
- flush=1 at an edge:
  - occ -> 0, out_valid -> 0.
  - A capture due at that edge (state REQ) is discarded.
  - The FSM goes to GAP if it was in REQ, otherwise to IDLE.
  - No new REQ starts in the flush cycle.
  - out_cnt is not changed, and a pop coinciding with flush is not counted.
- out_ready is ignored when out_valid=0.

Decomposition:
- Shared package `buf_pkg`:
  - FSM state encoding constants S_IDLE=2'd0, S_REQ=2'd1, S_GAP=2'd2.
  - Default DATA_L.
- Sub-module `skid_q2`: 2-entry register queue.
  - Inputs: push, pop, flush, din.
  - Outputs: dout, occ[1:0].
  - Used once, for the holding queue.
- The FSM and counter live in `buf_reader`.

Test Plan:
- Reset then feed a buffer preloaded with 0x1111, 0x2222, 0x3333, with out_ready=1 -> buf_re pulses every 2 cycles. out_data sequence is 0x1111, 0x2222, 0x3333; out_cnt=3; FSM returns to IDLE with buf_re=0 once avail=0.
- Preload 5 words, hold out_ready=0 -> exactly 2 buf_re pulses, then buf_re stays 0 and occ=2. Release out_ready -> remaining 3 words arrive in order, with no loss or duplication.
- Empty buffer (avail=0) for 20 cycles -> buf_re never rises; out_valid=0. Then one write of 0xBEEF -> out_valid=1 with out_data=0xBEEF within 3 cycles of avail rising.
- Assert flush in the REQ cycle with occ=1 and out_ready=1 -> next cycle out_valid=0; the captured word is dropped; out_cnt is unchanged; the next word read from the buffer is delivered normally.
- Preset traffic until out_cnt=0xFFFE, deliver 3 words -> out_cnt goes 0xFFFF, 0x0000, 0x0001.
- Drive rst=0 asynchronously mid-GAP with occ=2 -> out_valid, buf_re and out_cnt drop to 0 without waiting for a clk edge. After rst=1, normal draining resumes.

Source files
------------

// File: rtl/buf_pkg.sv
// buf_pkg: shared definitions for the buffer consumer front end.
//   state_t    : FSM encoding of buf_reader (S_IDLE=0, S_REQ=1, S_GAP=2)
//   DATA_L_DEF : default word width, matching the team's buffer FIFO
package buf_pkg;

    localparam int DATA_L_DEF = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_q2.sv
// skid_q2: two-entry register queue holding words already read from the buffer.
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   push, din    append din at the tail (caller guarantees occ < 2 or a same-edge pop)
//   pop          remove the head (ignored while empty)
//   flush        discard all entries; wins over push and pop
//   dout         head entry; keeps its last value once the queue drains
//   occ          number of valid entries (0..2)
module skid_q2 #(
    parameter int DATA_L = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_L-1:0] din,
    output logic [DATA_L-1:0] dout,
    output logic [1:0]        occ
);

    logic [DATA_L-1:0] e0;
    logic [DATA_L-1:0] e1;
    logic              do_pop;

    assign do_pop = pop && (occ != 2'd0);
    assign dout   = e0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            e0  <= '0;
            e1  <= '0;
            occ <= 2'd0;
        end else if (flush) begin
            occ <= 2'd0;
        end else if (push && do_pop) begin
            // Occupancy unchanged: head advances, new word takes the tail.
            if (occ == 2'd1) begin
                e0 <= din;
            end else begin
                e0 <= e1;
                e1 <= din;
            end
        end else if (push) begin
            if (occ == 2'd0) e0 <= din;
            else             e1 <= din;
            occ <= occ + 2'd1;
        end else if (do_pop) begin
            // Draining the last entry leaves e0 untouched (stale but harmless).
            if (occ == 2'd2) e0 <= e1;
            occ <= occ - 2'd1;
        end
    end

endmodule

// File: rtl/buf_reader.sv
// buf_reader: drains a buffer FIFO through its avail/re/dout interface and
// presents the words downstream on a valid/ready handshake.
//
// Handshake: a word transfers at a rising clk edge where out_valid=1 and
// out_ready=1; out_ready is don't-care while out_valid=0, and out_valid never
// depends combinationally on out_ready.
//
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   buf_avail    buffer non-empty
//   buf_re       one-cycle read strobe; the buffer pops on its rising edge
//   buf_dout     buffer data, captured at the edge ending the strobe cycle
//   flush        synchronous discard of held and in-flight words
//   out_valid    out_data carries a word
//   out_ready    downstream accepts the word
//   out_data     head of the skid queue
//   out_cnt      delivered-word count, wraps modulo 2^CNT_L
//   dbg_state    current FSM state for observation
module buf_reader
    import buf_pkg::*;
#(
    parameter int DATA_L = DATA_L_DEF,
    parameter int CNT_L  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              buf_avail,
    output logic              buf_re,
    input  logic [DATA_L-1:0] buf_dout,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_L-1:0] out_data,
    output logic [CNT_L-1:0]  out_cnt,
    output logic [1:0]        dbg_state
);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] occ;
    logic [1:0] occ_after_pop;
    logic       push;
    logic       pop;

    // A pop coinciding with flush is neither performed nor counted.
    assign pop           = out_valid && out_ready && !flush;
    assign push          = (state == S_REQ) && !flush;
    assign occ_after_pop = occ - {1'b0, pop};

    // Both outputs decode flops only, so no input reaches them combinationally.
    assign buf_re    = (state == S_REQ);
    assign out_valid = (occ != 2'd0);
    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    // Room is checked before issuing a read, so the capture at the end of
    // REQ always fits even if downstream stalls indefinitely.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (!flush && buf_avail && (occ < 2'd2)) state_nxt = S_REQ;
            end
            S_REQ: begin
                state_nxt = S_GAP;
            end
            S_GAP: begin
                // GAP never captures, so only this edge's pop can free a slot.
                if (!flush && buf_avail && (occ_after_pop < 2'd2)) state_nxt = S_REQ;
                else                                              state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     out_cnt <= '0;
        else if (pop) out_cnt <= out_cnt + {{(CNT_L-1){1'b0}}, 1'b1};
    end

    skid_q2 #(
        .DATA_L(DATA_L)
    ) u_q (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (buf_dout),
        .dout  (out_data),
        .occ   (occ)
    );

endmodule

// File: tb/tb_buf_reader.sv
// Bench for buf_reader. A queue models the upstream buffer (pops on each
// rising edge of buf_re); a reference FIFO holds the words the reader should
// be presenting, and a delivered-word count models out_cnt. The counter is
// built 8 bits wide so the wrap-around is reachable in a short run.
module tb_buf_reader;
    import buf_pkg::*;

    localparam int DW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          buf_avail;
    logic          buf_re;
    logic [DW-1:0] buf_dout;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_cnt;
    logic [1:0]    dbg_state;

    int ncmp  = 0;
    int nfail = 0;

    buf_reader #(.DATA_L(DW), .CNT_L(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .buf_avail (buf_avail),
        .buf_re    (buf_re),
        .buf_dout  (buf_dout),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cnt   (out_cnt),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
        ncmp++;
        assert (obs === req) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
        end
    endtask

    // Upstream buffer model.
    logic [DW-1:0] buf_q[$];
    int            rises = 0;
    bit            rec_rise = 0;
    longint        rise_t[$];

    task automatic push_word(input logic [DW-1:0] w);
        buf_q.push_back(w);
        buf_avail = 1'b1;
    endtask

    always @(posedge buf_re) begin
        rises++;
        if (rec_rise) rise_t.push_back(longint'($time));
        check("re_nonempty", {31'd0, buf_q.size() != 0}, 32'd1);
        if (buf_q.size() != 0) buf_dout = buf_q.pop_front();
        buf_avail = (buf_q.size() != 0);
    end

    // Reference model: words held by the reader, and words delivered.
    logic [DW-1:0] exp_q[$];
    logic [CW-1:0] mcnt = '0;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_valid", {31'd0, out_valid}, 32'd0);
            check("rst_re",    {31'd0, buf_re},    32'd0);
            check("rst_cnt",   {24'd0, out_cnt},   32'd0);
            exp_q.delete();
            mcnt = '0;
        end else begin
            check("valid", {31'd0, out_valid}, {31'd0, exp_q.size() != 0});
            if (exp_q.size() != 0) check("data", {16'd0, out_data}, {16'd0, exp_q[0]});
            check("cnt", {24'd0, out_cnt}, {24'd0, mcnt});
            if (flush) begin
                exp_q.delete();
            end else begin
                if (out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    mcnt++;
                end
                if (buf_re) exp_q.push_back(buf_dout);
                check("occ_le2", {31'd0, exp_q.size() <= 2}, 32'd1);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        bit hit;
        logic [CW-1:0] base;
        logic [CW-1:0] wrap_exp[3];
        wrap_exp[0] = 8'hFF;
        wrap_exp[1] = 8'h00;
        wrap_exp[2] = 8'h01;

        rst = 1'b0; flush = 1'b0; out_ready = 1'b0; buf_avail = 1'b0; buf_dout = '0;
        #3;
        check("reset_valid", {31'd0, out_valid}, 32'd0);
        check("reset_re",    {31'd0, buf_re},    32'd0);
        check("reset_data",  {16'd0, out_data},  32'd0);
        check("reset_cnt",   {24'd0, out_cnt},   32'd0);
        check("reset_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        tick(2);
        rst = 1'b1;

        // Three preloaded words, downstream always ready.
        rec_rise = 1;
        push_word(16'h1111); push_word(16'h2222); push_word(16'h3333);
        out_ready = 1'b1;
        tick(12);
        rec_rise = 0;
        check("t1_pulses", rise_t.size(), 32'd3);
        if (rise_t.size() == 3) begin
            check("t1_gap01", 32'(rise_t[1] - rise_t[0]), 32'd20);
            check("t1_gap12", 32'(rise_t[2] - rise_t[1]), 32'd20);
        end
        check("t1_cnt",   {24'd0, out_cnt},   32'd3);
        check("t1_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
        check("t1_re",    {31'd0, buf_re},    32'd0);

        // Downstream stalled: only two reads may be issued.
        out_ready = 1'b0;
        r0 = rises;
        for (int i = 0; i < 5; i++) push_word(16'hA001 + 16'(i));
        tick(15);
        check("t2_pulses", rises - r0, 32'd2);
        check("t2_re",     {31'd0, buf_re},    32'd0);
        check("t2_valid",  {31'd0, out_valid}, 32'd1);
        check("t2_head",   {16'd0, out_data},  32'hA001);
        out_ready = 1'b1;
        tick(20);
        check("t2_cnt",   {24'd0, out_cnt},   32'd8);
        check("t2_empty", buf_q.size(),       32'd0);
        check("t2_valid_end", {31'd0, out_valid}, 32'd0);

        // Empty buffer, then a single word.
        out_ready = 1'b0;
        r0 = rises;
        tick(20);
        check("t3_no_re", rises - r0, 32'd0);
        check("t3_valid", {31'd0, out_valid}, 32'd0);
        push_word(16'hBEEF);
        hit = 0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            if (out_valid && out_data == 16'hBEEF) begin hit = 1; break; end
        end
        check("t3_beef", {31'd0, hit}, 32'd1);
        out_ready = 1'b1;
        tick(4);

        // Flush during a read with one word already held.
        out_ready = 1'b0;
        push_word(16'hC001); push_word(16'hC002); push_word(16'hC003);
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (buf_re && out_valid) begin hit = 1; break; end
        end
        check("t4_req_occ1", {31'd0, hit}, 32'd1);
        base = mcnt;
        flush = 1'b1; out_ready = 1'b1;
        tick(1);
        flush = 1'b0;
        check("t4_valid", {31'd0, out_valid}, 32'd0);
        check("t4_cnt",   {24'd0, out_cnt},   {24'd0, base});
        tick(6);
        check("t4_cnt_after", {24'd0, out_cnt}, {24'd0, base + 8'd1});

        // Randomised traffic with stalls and occasional flushes.
        for (int i = 0; i < 400; i++) begin
            if (buf_q.size() < 4 && $urandom_range(0, 1) == 1) push_word(16'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 29) == 0);
            tick(1);
        end
        flush = 1'b0; out_ready = 1'b1;
        tick(20);

        // Counter wrap.
        for (int i = 0; i < 300 && mcnt != 8'hFE; i++) begin
            push_word(16'($urandom));
            tick(4);
        end
        check("t5_at_fe", {24'd0, mcnt}, 32'hFE);
        for (int k = 0; k < 3; k++) begin
            push_word(16'($urandom));
            tick(4);
            check("t5_wrap", {24'd0, out_cnt}, {24'd0, wrap_exp[k]});
        end

        // Asynchronous reset in GAP with two words held.
        out_ready = 1'b0;
        r0 = rises;
        for (int i = 0; i < 4; i++) push_word(16'hD001 + 16'(i));
        hit = 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (dbg_state == S_GAP && rises - r0 == 2) begin hit = 1; break; end
        end
        check("t6_gap_occ2", {31'd0, hit}, 32'd1);
        #1;
        rst = 1'b0;
        #1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_re",    {31'd0, buf_re},    32'd0);
        check("t6_cnt",   {24'd0, out_cnt},   32'd0);
        check("t6_data",  {16'd0, out_data},  32'd0);
        tick(1);
        rst = 1'b1;
        out_ready = 1'b1;
        tick(12);
        check("t6_cnt_after", {24'd0, out_cnt}, 32'd2);
        check("t6_empty",     buf_q.size(),     32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
